// File: rtl/gate_test_sequencer_if.sv
// Handshake and gate-under-test bus for gate_test_sequencer.
// The slave modport is the sequencer. The master modport is the controller
// plus the gate under test.
interface gate_test_sequencer_if #(
    parameter int N_INPUTS = 3
);
    logic                start;
    logic                mode;
    logic [N_INPUTS-1:0] dut_i;
    logic                dut_o;
    logic                busy;
    logic                done;
    logic                pass;
    logic [N_INPUTS:0]   err_count;
    logic [N_INPUTS-1:0] fail_vec;

    modport master (
        output start, mode, dut_o,
        input  dut_i, busy, done, pass, err_count, fail_vec
    );

    modport slave (
        input  start, mode, dut_o,
        output dut_i, busy, done, pass, err_count, fail_vec
    );
endinterface

// File: rtl/gate_test_sequencer.sv
// gate_test_sequencer: exhaustively sweeps every input vector of an N_INPUTS-wide
// gate. Each vector is held for SETTLE_CYCLES cycles, and then the gate output
// is compared against AND (mode=1) or OR (mode=0) of the vector bits.
// Optional feature: define GATE_SEQ_STOP_ON_FAIL_EN to end the sweep at the
// first mismatching vector.
module gate_test_sequencer #(
    parameter int N_INPUTS      = 3,
    parameter int SETTLE_CYCLES = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    gate_test_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    // The vector counter has one spare bit, so the terminal compare is an exact match.
    localparam logic [N_INPUTS:0] LAST_VEC    = (N_INPUTS+1)'((1 << N_INPUTS) - 1);
    localparam logic [7:0]        SETTLE_LOAD = 8'(SETTLE_CYCLES);

    state_t              state;
    state_t              next_state;
    logic [N_INPUTS:0]   vec;
    logic [7:0]          settle_cnt;
    logic                mode_q;
    logic                first_fail;
    logic [N_INPUTS:0]   err_cnt;
    logic [N_INPUTS-1:0] fail_vec_q;
    logic                expected;
    logic                mismatch;
    logic                stop_on_fail;

`ifdef GATE_SEQ_STOP_ON_FAIL_EN
    assign stop_on_fail = 1'b1;
`else
    assign stop_on_fail = 1'b0;
`endif

    assign expected = mode_q ? (&vec[N_INPUTS-1:0]) : (|vec[N_INPUTS-1:0]);
    assign mismatch = (bus.dut_o != expected);

    // State register; reset aborts any sweep in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: one DRIVE cycle, SETTLE_CYCLES settle cycles, and one CHECK cycle per vector.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    next_state = DRIVE;
                end
            end
            DRIVE: begin
                next_state = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt <= 8'd1) begin
                    next_state = CHECK;
                end
            end
            CHECK: begin
                if ((vec == LAST_VEC) || (stop_on_fail && mismatch)) begin
                    next_state = DONE;
                end else begin
                    next_state = DRIVE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: start capture, settle countdown, error bookkeeping, and vector advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec        <= '0;
            settle_cnt <= '0;
            mode_q     <= 1'b0;
            first_fail <= 1'b0;
            err_cnt    <= '0;
            fail_vec_q <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        mode_q     <= bus.mode;
                        vec        <= '0;
                        err_cnt    <= '0;
                        fail_vec_q <= '0;
                        first_fail <= 1'b0;
                    end
                end
                DRIVE: begin
                    settle_cnt <= SETTLE_LOAD;
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt - 8'd1;
                end
                CHECK: begin
                    if (mismatch) begin
                        err_cnt <= err_cnt + 1'b1;
                        if (!first_fail) begin
                            fail_vec_q <= vec[N_INPUTS-1:0];
                            first_fail <= 1'b1;
                        end
                    end
                    if (next_state == DRIVE) begin
                        vec <= vec + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.dut_i     = vec[N_INPUTS-1:0];
    assign bus.busy      = (state == DRIVE) || (state == SETTLE) || (state == CHECK);
    assign bus.done      = (state == DONE);
    assign bus.pass      = (state == DONE) && (err_cnt == '0);
    assign bus.err_count = err_cnt;
    assign bus.fail_vec  = fail_vec_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed testbench for gate_test_sequencer.
// Instance 0 uses the default parameters and a selectable gate model.
// Instance 1 uses SETTLE_CYCLES=1 and an AND gate.
// GATE_SEQ_STOP_ON_FAIL_EN selects the expected results for the failing sweeps.
module tb_gate_test_sequencer;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   gate_sel = 0;
    int   cycles;

    gate_test_sequencer_if #(.N_INPUTS(3)) bus0 ();
    gate_test_sequencer_if #(.N_INPUTS(3)) bus1 ();

    gate_test_sequencer #(.N_INPUTS(3), .SETTLE_CYCLES(4)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    gate_test_sequencer #(.N_INPUTS(3), .SETTLE_CYCLES(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate-under-test models: 0 = AND, 1 = OR, otherwise stuck-at-0
    always_comb begin
        case (gate_sel)
            0:       bus0.dut_o = &bus0.dut_i;
            1:       bus0.dut_o = |bus0.dut_i;
            default: bus0.dut_o = 1'b0;
        endcase
    end

    always_comb bus1.dut_o = &bus1.dut_i;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    // Start a sweep on instance 0, then count the cycles from acceptance until done.
    // Optionally pulse start and flip mode at cycle glitch_at, or hold start high.
    task automatic applyStimulus(input int gate, input logic m, input int glitch_at,
                                 input bit hold, output int n);
        gate_sel   = gate;
        bus0.mode  = m;
        bus0.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) bus0.start = 1'b0;
        checkOutput("busy_after_start", 32'(bus0.busy), 32'd1);
        n = 0;
        while (!bus0.done && n < 200) begin
            @(negedge clk);
            n++;
            if (glitch_at >= 0 && n == glitch_at) begin
                bus0.start = 1'b1;
                bus0.mode  = ~m;
            end else if (glitch_at >= 0 && n == glitch_at + 1) begin
                bus0.start = 1'b0;
                bus0.mode  = m;
            end
        end
    endtask

    task automatic checkResult(input string tag, input int n, input int n_exp, input int err_exp,
                               input int fail_exp, input int pass_exp, input int dut_i_exp);
        checkOutput({tag, "_cycles"}, 32'(n), 32'(n_exp));
        checkOutput({tag, "_done"}, 32'(bus0.done), 32'd1);
        checkOutput({tag, "_busy"}, 32'(bus0.busy), 32'd0);
        checkOutput({tag, "_pass"}, 32'(bus0.pass), 32'(pass_exp));
        checkOutput({tag, "_err_count"}, 32'(bus0.err_count), 32'(err_exp));
        checkOutput({tag, "_fail_vec"}, 32'(bus0.fail_vec), 32'(fail_exp));
        checkOutput({tag, "_dut_i"}, 32'(bus0.dut_i), 32'(dut_i_exp));
    endtask

    initial begin
        int k;
        rst_n      = 1'b0;
        bus0.start = 1'b0;
        bus0.mode  = 1'b0;
        bus1.start = 1'b0;
        bus1.mode  = 1'b0;

        #2;
        checkOutput("rst_dut_i", 32'(bus0.dut_i), 32'd0);
        checkOutput("rst_busy", 32'(bus0.busy), 32'd0);
        checkOutput("rst_done", 32'(bus0.done), 32'd0);
        checkOutput("rst_pass", 32'(bus0.pass), 32'd0);
        checkOutput("rst_err_count", 32'(bus0.err_count), 32'd0);
        checkOutput("rst_fail_vec", 32'(bus0.fail_vec), 32'd0);

        // Release reset and present start at once; the next rising edge must accept it.
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 1'b1, -1, 1'b0, cycles);
        checkResult("and_mode1", cycles, 48, 0, 0, 1, 7);

        applyStimulus(1, 1'b0, -1, 1'b0, cycles);
        checkResult("or_mode0", cycles, 48, 0, 0, 1, 7);

`ifdef GATE_SEQ_STOP_ON_FAIL_EN
        applyStimulus(2, 1'b0, -1, 1'b0, cycles);
        checkResult("stuck0_mode0", cycles, 12, 1, 1, 0, 1);
        applyStimulus(0, 1'b0, -1, 1'b0, cycles);
        checkResult("and_as_or", cycles, 12, 1, 1, 0, 1);
`else
        applyStimulus(2, 1'b0, -1, 1'b0, cycles);
        checkResult("stuck0_mode0", cycles, 48, 7, 1, 0, 7);
        applyStimulus(0, 1'b0, -1, 1'b0, cycles);
        checkResult("and_as_or", cycles, 48, 6, 1, 0, 7);
`endif

        // A start pulse and a mode flip in mid-sweep must both be ignored.
        applyStimulus(0, 1'b1, 10, 1'b0, cycles);
        checkResult("start_ignored", cycles, 48, 0, 0, 1, 7);

        // With start held high, the sweep restarts on the cycle after DONE.
        applyStimulus(0, 1'b1, -1, 1'b1, cycles);
        checkOutput("held_cycles", 32'(cycles), 32'd48);
        checkOutput("held_done", 32'(bus0.done), 32'd1);
        @(negedge clk);
        bus0.start = 1'b0;
        checkOutput("held_restart_busy", 32'(bus0.busy), 32'd1);
        checkOutput("held_restart_done", 32'(bus0.done), 32'd0);
        checkOutput("held_restart_dut_i", 32'(bus0.dut_i), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Assert reset during SETTLE of vector 5; the outputs must clear without a clock edge.
        gate_sel   = 0;
        bus0.mode  = 1'b1;
        bus0.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus0.start = 1'b0;
        repeat (32) @(negedge clk);
        checkOutput("mid_vec5_dut_i", 32'(bus0.dut_i), 32'd5);
        checkOutput("mid_vec5_busy", 32'(bus0.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_dut_i", 32'(bus0.dut_i), 32'd0);
        checkOutput("mid_rst_busy", 32'(bus0.busy), 32'd0);
        checkOutput("mid_rst_done", 32'(bus0.done), 32'd0);
        checkOutput("mid_rst_pass", 32'(bus0.pass), 32'd0);
        checkOutput("mid_rst_err_count", 32'(bus0.err_count), 32'd0);
        checkOutput("mid_rst_fail_vec", 32'(bus0.fail_vec), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 1'b1, -1, 1'b0, cycles);
        checkResult("after_reset", cycles, 48, 0, 0, 1, 7);

        // With SETTLE_CYCLES=1, each vector occupies exactly 3 cycles and a sweep takes 24.
        bus1.mode  = 1'b1;
        bus1.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.start = 1'b0;
        checkOutput("s1_dut_i_k0", 32'(bus1.dut_i), 32'd0);
        k = 0;
        while (!bus1.done && k < 100) begin
            @(negedge clk);
            k++;
            if (k < 24) begin
                checkOutput($sformatf("s1_dut_i_k%0d", k), 32'(bus1.dut_i), 32'(k / 3));
            end
        end
        checkOutput("s1_cycles", 32'(k), 32'd24);
        checkOutput("s1_pass", 32'(bus1.pass), 32'd1);
        checkOutput("s1_err_count", 32'(bus1.err_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_test_sequencer.md
GATE_TEST_SEQUENCER -- requirements
Module: gate_test_sequencer

Interface
REQ-001 Parameter N_INPUTS, default 3: width of the gate-under-test input vector; legal range 2..8.
REQ-002 Parameter SETTLE_CYCLES, default 4: cycles each vector is held before the output is sampled; legal range 1..255.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port start  input  1  request to run one exhaustive sweep; sampled only in IDLE or DONE.
REQ-006 Port mode  input  1  expected function: 1 = AND, 0 = OR; captured on accepted start.
REQ-007 Port dut_i  output  N_INPUTS  vector driven to the gate under test.
REQ-008 Port dut_o  input  1  gate-under-test output.
REQ-009 Port busy  output  1  high from accepted start until DONE is entered.
REQ-010 Port done  output  1  high while in DONE.
REQ-011 Port pass  output  1  valid while done; 1 when err_count is zero.
REQ-012 Port err_count  output  N_INPUTS+1  number of mismatching vectors in the last sweep.
REQ-013 Port fail_vec  output  N_INPUTS  first mismatching vector of the last sweep; zero if none.

Function
REQ-014 The FSM SHALL have states IDLE, DRIVE, SETTLE, CHECK, DONE.
REQ-015 IDLE or DONE with start=1 SHALL go to DRIVE, capture mode, and clear vector, err_count, fail_vec and the first-fail flag.
REQ-016 DRIVE SHALL last one cycle, place the current vector on dut_i, load the settle counter with SETTLE_CYCLES, and go to SETTLE.
REQ-017 SETTLE SHALL decrement the counter each cycle and go to CHECK on the cycle it reaches 1; dut_i SHALL stay constant.
REQ-018 CHECK SHALL last one cycle and compare dut_o with the expected value: AND of all vector bits (mode=1) or OR of all vector bits (mode=0).
REQ-019 On a mismatch in CHECK, err_count SHALL increment by 1, and fail_vec SHALL take the vector only if this is the first mismatch of the sweep.
REQ-020 CHECK on vector 2^N_INPUTS-1 SHALL go to DONE; otherwise the vector SHALL increment by 1 and the FSM SHALL go to DRIVE.
REQ-021 Each vector SHALL take exactly SETTLE_CYCLES+2 cycles, and a full sweep SHALL take 2^N_INPUTS*(SETTLE_CYCLES+2) cycles from the accepted start to the DONE entry.
REQ-022 The vector counter SHALL be N_INPUTS+1 bits wide so that the terminal test does not depend on wrap-around; err_count SHALL never wrap, with a maximum of 2^N_INPUTS.
REQ-023 start while busy SHALL be ignored and SHALL have no effect on the sweep.
REQ-024 mode changes while busy SHALL be ignored.
REQ-025 DONE SHALL hold done, pass, err_count, fail_vec and the last dut_i until a new start is accepted.
REQ-026 start=1 held continuously SHALL restart the sweep on the cycle after DONE is entered.

Reset
REQ-027 rst_n low SHALL, without waiting for clk, force IDLE with dut_i=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, and the internal counters cleared.
REQ-028 Reset asserted mid-sweep SHALL abort the sweep with no result retained.
REQ-029 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-030 Macro GATE_SEQ_STOP_ON_FAIL_EN defined: the first mismatch in CHECK SHALL go directly to DONE with err_count=1 and fail_vec set to that vector.
REQ-031 Macro GATE_SEQ_STOP_ON_FAIL_EN undefined: every sweep SHALL cover all 2^N_INPUTS vectors, as specified in REQ-020.

Verification
REQ-032 Correct AND gate, mode=1, defaults, one start pulse -> done after 48 cycles, pass=1, err_count=0, fail_vec=0.
REQ-033 Correct OR gate, mode=0 -> pass=1; gate stuck-at-0 with mode=0 -> err_count=7, fail_vec=3'b001.
REQ-034 AND gate bound while mode=0 (macro undefined) -> err_count=6, fail_vec=3'b001; with macro defined -> done at cycle 12, err_count=1.
REQ-035 start pulsed at cycle 10 of a sweep -> no restart, done still at cycle 48; start held high -> DRIVE re-entered the cycle after DONE.
REQ-036 rst_n pulsed low during SETTLE of vector 5 -> all outputs 0 immediately, IDLE; the next start runs a full, clean sweep.
REQ-037 SETTLE_CYCLES=1 -> each vector holds for exactly 3 cycles, and dut_i is stable throughout SETTLE and CHECK.
